// File: rtl/nand_nor_sweep_checker_if.sv
// Control/status bundle for nand_nor_sweep_checker.
// The slave side is the checker; the master side is the lab top or a bench.
interface nand_nor_sweep_checker_if #(
  parameter int unsigned N_IN = 4
);
  logic            start;
  logic            step_mode;
  logic            step;
  logic            inj_fault;
  logic [N_IN-1:0] vec_out;
  logic            f_nand;
  logic            f_nor;
  logic            f_ref;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_valid;

  modport master (
    output start, step_mode, step, inj_fault,
    input  vec_out, f_nand, f_nor, f_ref, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );

  modport slave (
    input  start, step_mode, step, inj_fault,
    output vec_out, f_nand, f_nor, f_ref, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/nand_nor_sweep_checker.sv
// Self-checking sweep of two gate-level realisations of an N_IN-input function:
// NAND-NAND sum-of-products and NOR-NOR product-of-sums, both built from TRUTH.
// An FSM walks every input vector, registers both outputs and the reference,
// counts mismatching vectors and remembers the first failing one.
module nand_nor_sweep_checker #(
  parameter int unsigned                 N_IN  = 4,
  parameter logic [(1 << N_IN)-1:0]      TRUTH = 16'h1F55
) (
  input logic                      clk,
  input logic                      rst,
  nand_nor_sweep_checker_if.slave  bus
);
  localparam int unsigned     NV      = 1 << N_IN;
  localparam logic [NV-1:0]   TRUTH_V = TRUTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            step_mode_q, step_mode_d;
  logic            f_nand_q, f_nand_d;
  logic            f_nor_q, f_nor_d;
  logic            f_ref_q, f_ref_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fev_q, fev_d;
  logic            fevv_q, fevv_d;
  logic            mism;

  logic [N_IN-1:0] x, xn;
  logic [NV-1:0]   term_nand, term_nor;
  logic            comb_nand, comb_nor, comb_ref;

  assign x        = vec_q;
  assign comb_ref = TRUTH_V[vec_q];

  // Literal inverters: NAND gates with tied inputs
  for (genvar j = 0; j < N_IN; j++) begin : g_inv
    nand u_inv (xn[j], x[j], x[j]);
  end

  // First level: a NAND minterm per 1-bit, a NOR maxterm per 0-bit.
  // Unused slots are tied to the identity of the output gate (1 for NAND, 0 for NOR),
  // which also yields the constant outputs for all-0 / all-1 tables.
  // Wide gates are chains of scalar 2-input stages kept in per-stage scopes.
  for (genvar i = 0; i < NV; i++) begin : g_term
    if (TRUTH_V[i]) begin : g_on
      logic [N_IN-1:0] lit;
      for (genvar j = 0; j < N_IN; j++) begin : g_lit
        if (((i >> j) & 1) == 1) begin : g_pos
          assign lit[j] = x[j];
        end else begin : g_neg
          assign lit[j] = xn[j];
        end
      end
      for (genvar k = 0; k < N_IN; k++) begin : g_and
        logic a;
        if (k == 0) begin : g_first
          assign a = lit[0];
        end else begin : g_next
          logic t;
          nand u_t (t, g_and[k-1].a, lit[k]);
          nand u_a (a, t, t);
        end
      end
      nand u_term (term_nand[i], g_and[N_IN-1].a, g_and[N_IN-1].a);
      assign term_nor[i] = 1'b0;
    end else begin : g_off
      logic [N_IN-1:0] lit;
      for (genvar j = 0; j < N_IN; j++) begin : g_lit
        if (((i >> j) & 1) == 1) begin : g_pos
          assign lit[j] = xn[j];
        end else begin : g_neg
          assign lit[j] = x[j];
        end
      end
      for (genvar k = 0; k < N_IN; k++) begin : g_or
        logic o;
        if (k == 0) begin : g_first
          assign o = lit[0];
        end else begin : g_next
          logic t;
          nor u_t (t, g_or[k-1].o, lit[k]);
          nor u_o (o, t, t);
        end
      end
      nor u_term (term_nor[i], g_or[N_IN-1].o, g_or[N_IN-1].o);
      assign term_nand[i] = 1'b1;
    end
  end

  // Second level: output NAND over all minterms, output NOR over all maxterms
  for (genvar k = 0; k < NV; k++) begin : g_out
    logic a, o;
    if (k == 0) begin : g_first
      assign a = term_nand[0];
      assign o = term_nor[0];
    end else begin : g_next
      logic ta, to;
      nand u_ta (ta, g_out[k-1].a, term_nand[k]);
      nand u_a  (a, ta, ta);
      nor  u_to (to, g_out[k-1].o, term_nor[k]);
      nor  u_o  (o, to, to);
    end
  end
  nand u_out_nand (comb_nand, g_out[NV-1].a, g_out[NV-1].a);
  nor  u_out_nor  (comb_nor,  g_out[NV-1].o, g_out[NV-1].o);

  // Sweep sequencing, sampling and error bookkeeping
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    step_mode_d = step_mode_q;
    f_nand_d    = f_nand_q;
    f_nor_d     = f_nor_q;
    f_ref_d     = f_ref_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fev_d       = fev_q;
    fevv_d      = fevv_q;
    mism        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          err_d       = '0;
          fev_d       = '0;
          fevv_d      = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          vec_d       = '0;
          busy_d      = 1'b1;
          step_mode_d = bus.step_mode;
          state_d     = S_APPLY;
        end
      end
      S_APPLY: begin
        if (!step_mode_q || bus.step) state_d = S_EVAL;
      end
      S_EVAL: begin
        f_nand_d = comb_nand;
        f_nor_d  = comb_nor ^ bus.inj_fault;
        f_ref_d  = comb_ref;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        mism = (f_nand_q != f_ref_q) || (f_nor_q != f_ref_q);
        if (mism) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fevv_q) begin
            fev_d  = vec_q;
            fevv_d = 1'b1;
          end
        end
        if (vec_q == '1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      step_mode_q <= 1'b0;
      f_nand_q    <= 1'b0;
      f_nor_q     <= 1'b0;
      f_ref_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fev_q       <= '0;
      fevv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      step_mode_q <= step_mode_d;
      f_nand_q    <= f_nand_d;
      f_nor_q     <= f_nor_d;
      f_ref_q     <= f_ref_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fevv_q      <= fevv_d;
    end
  end

  assign bus.vec_out         = vec_q;
  assign bus.f_nand          = f_nand_q;
  assign bus.f_nor           = f_nor_q;
  assign bus.f_ref           = f_ref_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevv_q;
endmodule
